// File: rtl/peripheral_spram_wb_arbiter_pkg.sv
// Shared types, cycle-type codes and the round-robin pick function for the
// SPRAM Wishbone arbiter.
package peripheral_spram_wb_arbiter_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Widest supported arbiter; the pick function works on this width and the
  // caller passes the real master count in n.
  localparam int MAX_MASTERS = 8;
  localparam int PTR_W       = 3;

  // One-hot grant for the first requester at or after ptr, wrapping at n.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [PTR_W-1:0]       ptr,
    input int                     n
  );
    logic [MAX_MASTERS-1:0] onehot;
    logic                   found;
    logic [PTR_W-1:0]       idx;
    int                     cand;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (k < n) begin
        cand = int'(ptr) + k;
        if (cand >= n) cand = cand - n;
        idx = PTR_W'(cand);
        if (!found && req[idx]) begin
          onehot[idx] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/peripheral_spram_rr_arbiter.sv
// Combinational round-robin picker: request vector plus priority pointer in,
// one-hot grant and its index out.
module peripheral_spram_rr_arbiter
  import peripheral_spram_wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int PW          = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [PW-1:0]          ptr_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [PW-1:0]          idx_o
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] pick;

  // Widen the request, pick the winner and encode its index.
  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_MASTERS-1:0] = req_i;
    pick                     = rr_pick(req_ext, PTR_W'(ptr_i), NUM_MASTERS);
    idx_o                    = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (pick[i]) idx_o = PW'(i);
    end
    grant_o = pick[NUM_MASTERS-1:0];
  end

endmodule

// File: rtl/peripheral_spram_wb_arbiter.sv
// N-master Wishbone arbiter in front of one SPRAM slave port. Round-robin
// grant held for the whole cycle, with a per-transfer stall watchdog.
module peripheral_spram_wb_arbiter
  import peripheral_spram_wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 64
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [DW-1:0]             m_dat_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [1:0]                s_bte_o,
  output logic [2:0]                s_cti_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int PW  = $clog2(NUM_MASTERS);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0]  LAST_IDX  = PW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [WDW-1:0]         wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [PW-1:0]          pick_idx;
  logic                   stb_raw;
  logic                   wdog_fire;

  peripheral_spram_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .PW          (PW)
  ) u_rr (
    .req_i   (m_cyc_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Route the granted master onto the slave port; all zero while nobody holds the bus.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_bte_o = '0;
    s_cti_o = '0;
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*4 +: 4];
        s_we_o  = m_we_i[i];
        s_bte_o = m_bte_i[i*2 +: 2];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_cyc_o = m_cyc_i[i];
        stb_raw = m_cyc_i[i] & m_stb_i[i];
      end
    end
  end

  // A real ack or err in the final watchdog cycle takes precedence over the timeout.
  assign wdog_fire = (TIMEOUT > 0) && stb_raw && !s_ack_i && !s_err_i && (wdog_q == WDOG_LAST);
  assign s_stb_o   = stb_raw & ~wdog_fire;
  assign m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
  assign m_err_o   = grant_q & {NUM_MASTERS{s_err_i | wdog_fire}};
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;

  // Count stalled strobe cycles; any response, idle strobe or timeout restarts the count.
  always_comb begin
    wdog_d = wdog_q + WDW'(1);
    if (!stb_raw || s_ack_i || s_err_i || wdog_fire) wdog_d = '0;
  end

  // Grant on any request from IDLE, release when the granted master drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!m_cyc_i[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, pointer and watchdog registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_peripheral_spram_wb_arbiter.sv
// Self-checking bench for peripheral_spram_wb_arbiter: 4 masters, TIMEOUT=16,
// registered-ack SPRAM stub that can be muted to provoke the watchdog.
module tb_peripheral_spram_wb_arbiter;
  import peripheral_spram_wb_arbiter_pkg::*;

  localparam int NM = 4;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [31:0]   m_adr;
  logic [127:0]  m_dat;
  logic [15:0]   m_sel;
  logic [3:0]    m_we;
  logic [7:0]    m_bte;
  logic [11:0]   m_cti;
  logic [3:0]    m_cyc;
  logic [3:0]    m_stb;
  logic [3:0]    m_ack_o;
  logic [3:0]    m_err_o;
  logic [31:0]   m_dat_o;
  logic [7:0]    s_adr_o;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o;
  logic [1:0]    s_bte_o;
  logic [2:0]    s_cti_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic          stubAck;
  logic          stubErr = 1'b0;
  logic [31:0]   stubDat;
  logic [2:0]    stubCti;
  logic          stubMute;
  logic [3:0]    grant_o;
  logic [31:0]   mem [256];

  int errors;
  int checks;

  always #5 wb_clk_i = ~wb_clk_i;

  peripheral_spram_wb_arbiter #(
    .NUM_MASTERS (NM),
    .AW          (8),
    .DW          (32),
    .TIMEOUT     (16)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_we_i   (m_we),
    .m_bte_i  (m_bte),
    .m_cti_i  (m_cti),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_dat_o  (m_dat_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_bte_o  (s_bte_o),
    .s_cti_o  (s_cti_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_ack_i  (stubAck),
    .s_err_i  (stubErr),
    .s_dat_i  (stubDat),
    .grant_o  (grant_o)
  );

  // SPRAM stub: one-cycle registered ack, back-to-back acks while an incrementing burst runs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stubAck <= 1'b0;
      stubCti <= CTI_CLASSIC;
      stubDat <= '0;
    end else if (s_cyc_o && s_stb_o && !stubMute && (!stubAck || stubCti == CTI_INCR)) begin
      stubAck <= 1'b1;
      stubCti <= s_cti_o;
      stubDat <= mem[s_adr_o];
      if (s_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel_o[b]) mem[s_adr_o][b*8 +: 8] <= s_dat_o[b*8 +: 8];
        end
      end
    end else begin
      stubAck <= 1'b0;
    end
  end

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] expGrant;
    logic [3:0] expAck;
    logic       expScyc;
    logic [7:0] expSadr;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no response, expected one within the cycle budget", name);
  endtask

  task automatic setMaster(input int m, input logic on, input logic we, input logic [7:0] adr,
                           input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[m]          = on;
    m_stb[m]          = on;
    m_we[m]           = we;
    m_adr[m*8 +: 8]   = adr;
    m_dat[m*32 +: 32] = dat;
    m_cti[m*3 +: 3]   = cti;
    m_sel[m*4 +: 4]   = 4'hF;
  endtask

  // Each contention row: master i writes 0xA000_000i to address 0x20+i while its cyc bit is set.
  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < NM; i++) begin
      setMaster(i, v.cyc[i], 1'b1, 8'h20 + 8'(i), 32'hA000_0000 + 32'(i), CTI_CLASSIC);
    end
  endtask

  task automatic resetDut();
    wb_rst_i = 1'b1;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();
  endtask

  // Single classic transfer from an idle bus: grant one cycle later, then wait for the ack.
  task automatic doXfer(input int m, input logic we, input logic [7:0] adr, input logic [31:0] dat,
                        output logic [31:0] rdat);
    logic got;
    rdat = '0;
    got  = 1'b0;
    setMaster(m, 1'b1, we, adr, dat, CTI_CLASSIC);
    tick();
    checkOutput("xferGrant", 32'(grant_o), 32'(1 << m));
    for (int c = 0; c < 20 && !got; c++) begin
      if (m_ack_o != 4'b0000) begin
        got  = 1'b1;
        checkOutput("xferAckOnly", 32'(m_ack_o), 32'(1 << m));
        rdat = m_dat_o;
      end else begin
        tick();
      end
    end
    if (!got) failTimeout("xferAck");
    setMaster(m, 1'b0, 1'b0, adr, 32'h0, CTI_CLASSIC);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          acks;
    logic        gap, early, other, got;
    int          errFirst;

    errors   = 0;
    checks   = 0;
    stubMute = 1'b0;
    wb_rst_i = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
    m_bte = '0; m_cti = '0; m_cyc = '0; m_stb = '0;

    tbl[0]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{4'b1111, 4'b0001, 4'b0000, 1'b1, 8'h20};
    tbl[2]  = '{4'b1111, 4'b0001, 4'b0001, 1'b1, 8'h20};
    tbl[3]  = '{4'b1110, 4'b0001, 4'b0000, 1'b0, 8'h20};
    tbl[4]  = '{4'b1110, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[5]  = '{4'b1110, 4'b0010, 4'b0000, 1'b1, 8'h21};
    tbl[6]  = '{4'b1110, 4'b0010, 4'b0010, 1'b1, 8'h21};
    tbl[7]  = '{4'b1100, 4'b0010, 4'b0000, 1'b0, 8'h21};
    tbl[8]  = '{4'b1100, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[9]  = '{4'b1100, 4'b0100, 4'b0000, 1'b1, 8'h22};
    tbl[10] = '{4'b1100, 4'b0100, 4'b0100, 1'b1, 8'h22};
    tbl[11] = '{4'b1000, 4'b0100, 4'b0000, 1'b0, 8'h22};
    tbl[12] = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[13] = '{4'b1000, 4'b1000, 4'b0000, 1'b1, 8'h23};
    tbl[14] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 8'h23};
    tbl[15] = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 8'h23};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00};

    // Reset held 3 cycles while m1 requests: nothing may be granted.
    setMaster(1, 1'b1, 1'b0, 8'h05, 32'h0, CTI_CLASSIC);
    repeat (3) tick();
    checkOutput("rstGrant", 32'(grant_o), 32'h0);
    checkOutput("rstScyc",  32'(s_cyc_o), 32'h0);
    checkOutput("rstSstb",  32'(s_stb_o), 32'h0);
    checkOutput("rstAck",   32'(m_ack_o), 32'h0);
    checkOutput("rstErr",   32'(m_err_o), 32'h0);
    checkOutput("rstSadr",  32'(s_adr_o), 32'h0);
    setMaster(1, 1'b0, 1'b0, 8'h00, 32'h0, CTI_CLASSIC);
    wb_rst_i = 1'b0;
    tick();

    // Single master write then read back.
    $display("[TB] single master write/read");
    doXfer(1, 1'b1, 8'h10, 32'hDEAD_BEEF, rd);
    doXfer(1, 1'b0, 8'h10, 32'h0, rd);
    checkOutput("readBack", rd, 32'hDEAD_BEEF);

    // Four-way contention, two rounds from pointer 0.
    $display("[TB] contention");
    resetDut();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 17; i++) begin
        applyStimulus(tbl[i]);
        #1;
        checkOutput($sformatf("r%0d.row%0d.grant", r, i), 32'(grant_o), 32'(tbl[i].expGrant));
        checkOutput($sformatf("r%0d.row%0d.ack",   r, i), 32'(m_ack_o), 32'(tbl[i].expAck));
        checkOutput($sformatf("r%0d.row%0d.scyc",  r, i), 32'(s_cyc_o), 32'(tbl[i].expScyc));
        checkOutput($sformatf("r%0d.row%0d.sadr",  r, i), 32'(s_adr_o), 32'(tbl[i].expSadr));
        tick();
      end
    end
    for (int i = 0; i < NM; i++) begin
      checkOutput($sformatf("memM%0d", i), mem[8'h20 + 8'(i)], 32'hA000_0000 + 32'(i));
    end

    // m2 8-beat incrementing burst while m0 waits.
    $display("[TB] burst");
    setMaster(2, 1'b1, 1'b0, 8'h40, 32'h0, CTI_INCR);
    m_bte[5:4] = 2'b01;
    tick();
    checkOutput("burstGrant", 32'(grant_o), 32'b0100);
    checkOutput("burstCti",   32'(s_cti_o), 32'(CTI_INCR));
    checkOutput("burstBte",   32'(s_bte_o), 32'b01);
    setMaster(0, 1'b1, 1'b0, 8'h60, 32'h0, CTI_CLASSIC);
    acks = 0; gap = 1'b0; early = 1'b0; other = 1'b0;
    for (int c = 0; c < 40 && acks < 8; c++) begin
      tick();
      if (grant_o[0]) early = 1'b1;
      if ((m_ack_o & 4'b1011) != 4'b0000) other = 1'b1;
      if (m_ack_o[2]) begin
        acks++;
        m_adr[23:16] = m_adr[23:16] + 8'd1;
        if (acks == 7) m_cti[8:6] = CTI_EOB;
      end else if (acks > 0) begin
        gap = 1'b1;
      end
    end
    setMaster(2, 1'b0, 1'b0, 8'h00, 32'h0, CTI_CLASSIC);
    m_bte[5:4] = 2'b00;
    checkOutput("burstAcks",   32'(acks),  32'd8);
    checkOutput("burstGap",    32'(gap),   32'd0);
    checkOutput("burstM0Early", 32'(early), 32'd0);
    checkOutput("burstOtherAck", 32'(other), 32'd0);
    tick();
    checkOutput("burstDeadCycle", 32'(grant_o), 32'h0);
    tick();
    checkOutput("burstThenM0", 32'(grant_o), 32'b0001);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (m_ack_o[0]) got = 1'b1;
      else tick();
    end
    if (!got) failTimeout("m0AckAfterBurst");
    setMaster(0, 1'b0, 1'b0, 8'h00, 32'h0, CTI_CLASSIC);
    tick();
    tick();

    // Watchdog: slave never answers m3.
    $display("[TB] watchdog");
    stubMute = 1'b1;
    setMaster(3, 1'b1, 1'b0, 8'h70, 32'h0, CTI_CLASSIC);
    tick();
    checkOutput("wdogGrant", 32'(grant_o), 32'b1000);
    errFirst = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) tick();
      if (m_err_o[3] && errFirst == 0) errFirst = k;
      if (k == 15) checkOutput("wdogStbBefore", 32'(s_stb_o), 32'h1);
      if (k == 16) begin
        checkOutput("wdogErr",    32'(m_err_o), 32'b1000);
        checkOutput("wdogStbLow", 32'(s_stb_o), 32'h0);
        checkOutput("wdogNoAck",  32'(m_ack_o), 32'h0);
      end
    end
    checkOutput("wdogFirstErr",  32'(errFirst), 32'd16);
    checkOutput("wdogGrantHeld", 32'(grant_o),  32'b1000);
    checkOutput("wdogErrSingle", 32'(m_err_o),  32'h0);
    checkOutput("wdogStbAgain",  32'(s_stb_o),  32'h1);
    setMaster(3, 1'b0, 1'b0, 8'h00, 32'h0, CTI_CLASSIC);
    tick();
    tick();
    stubMute = 1'b0;

    // Reset at beat 3 of an m1 burst, after m0 moved the pointer to 1.
    $display("[TB] reset mid-burst");
    doXfer(0, 1'b0, 8'h10, 32'h0, rd);
    setMaster(1, 1'b1, 1'b0, 8'h50, 32'h0, CTI_INCR);
    tick();
    checkOutput("rbGrantM1", 32'(grant_o), 32'b0010);
    acks = 0;
    for (int c = 0; c < 20 && acks < 3; c++) begin
      tick();
      if (m_ack_o[1]) acks++;
    end
    if (acks < 3) failTimeout("rbBeat3");
    wb_rst_i = 1'b1;
    setMaster(0, 1'b1, 1'b0, 8'h11, 32'h0, CTI_CLASSIC);
    tick();
    checkOutput("rbGrant", 32'(grant_o), 32'h0);
    checkOutput("rbScyc",  32'(s_cyc_o), 32'h0);
    checkOutput("rbAck",   32'(m_ack_o), 32'h0);
    wb_rst_i = 1'b0;
    tick();
    checkOutput("rbM0First", 32'(grant_o), 32'b0001);
    m_cyc = '0;
    m_stb = '0;
    repeat (4) tick();
    checkOutput("endIdle", 32'(grant_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
